// File: rtl/sample_serializer_if.sv
// sample_serializer_if: groups the load side and the serial-line status of
// the sample serializer.
//   master : producer side (drives load/data_in/parity_en/clr_ovr,
//            observes the line and the status flags)
//   slave  : the serializer itself
interface sample_serializer_if;
  logic       load;
  logic [7:0] data_in;
  logic       parity_en;
  logic       clr_ovr;
  logic       tx_out;
  logic       busy;
  logic       buf_full;
  logic       overrun;
  logic       frame_done;

  modport master (
    output load, data_in, parity_en, clr_ovr,
    input  tx_out, busy, buf_full, overrun, frame_done
  );

  modport slave (
    input  load, data_in, parity_en, clr_ovr,
    output tx_out, busy, buf_full, overrun, frame_done
  );
endinterface

// File: rtl/sample_serializer.sv
// sample_serializer: turns each loaded sample byte into an asynchronous
// serial frame (start, 8 data bits LSB first, optional even parity,
// 1 or 2 stop bits). A one-entry holding buffer lets frames run
// back-to-back.
// Ports:
//   sysclk            system clock, rising edge
//   reset             asynchronous, active-high reset
//   sif.load          one-cycle strobe, data_in/parity_en valid
//   sif.data_in       sample byte
//   sif.parity_en     add even-parity bit to this byte's frame
//   sif.clr_ovr       clear sticky overrun
//   sif.tx_out        serial line, idles high
//   sif.busy          frame in progress
//   sif.buf_full      holding buffer occupied
//   sif.overrun       sticky: a byte was dropped
//   sif.frame_done    pulse on the last cycle of the last stop bit
//
// state  | meaning
// IDLE   | line high, waiting for load
// START  | start bit (line low)
// DATA   | data bits 0..7, LSB first
// PARITY | even-parity bit of the captured byte
// STOP   | STOP_BITS stop bits (line high)
module sample_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sysclk,
  input  logic                 reset,
  sample_serializer_if.slave   sif
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_par_q, buf_par_d;
  logic       buf_full_q, buf_full_d;
  logic       overrun_q, overrun_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ovr_set;
  logic       tick;
  logic       frame_end;

  // bit timer runs down; tick marks the last cycle of the current bit
  assign tick      = (div_q == 8'd0);
  assign frame_end = (state_q == STOP) && tick && (bit_q == STOP_LAST);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= 8'd0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'd0;
      par_q      <= 1'b0;
      buf_q      <= 8'd0;
      buf_par_q  <= 1'b0;
      buf_full_q <= 1'b0;
      overrun_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      buf_q      <= buf_d;
      buf_par_q  <= buf_par_d;
      buf_full_q <= buf_full_d;
      overrun_q  <= overrun_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = tick ? DIV_LAST : div_q - 8'd1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    buf_d      = buf_q;
    buf_par_d  = buf_par_q;
    buf_full_d = buf_full_q;
    ovr_set    = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = DIV_LAST;
        bit_d = 3'd0;
        if (sif.load) begin
          state_d = START;
          shreg_d = sif.data_in;
          par_d   = sif.parity_en;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = par_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          bit_d   = 3'd0;
        end
      end
      STOP: begin
        if (tick && (bit_q != STOP_LAST)) begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame end chains straight into the next start bit when a byte is
    // waiting; a load on that same cycle refills the buffer being drained.
    if (frame_end) begin
      bit_d = 3'd0;
      if (buf_full_q) begin
        state_d = START;
        shreg_d = buf_q;
        par_d   = buf_par_q;
        if (sif.load) begin
          buf_d     = sif.data_in;
          buf_par_d = sif.parity_en;
        end else begin
          buf_full_d = 1'b0;
        end
      end else if (sif.load) begin
        state_d = START;
        shreg_d = sif.data_in;
        par_d   = sif.parity_en;
      end else begin
        state_d = IDLE;
      end
    end else if ((state_q != IDLE) && sif.load) begin
      if (!buf_full_q) begin
        buf_d      = sif.data_in;
        buf_par_d  = sif.parity_en;
        buf_full_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[bit_d];
      PARITY:  tx_d = ^shreg_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == STOP) && (bit_d == STOP_LAST) && (div_d == 8'd0);
    overrun_d = ovr_set | (overrun_q & ~sif.clr_ovr);
  end

  assign sif.tx_out     = tx_q;
  assign sif.busy       = busy_q;
  assign sif.buf_full   = buf_full_q;
  assign sif.overrun    = overrun_q;
  assign sif.frame_done = done_q;

endmodule

// File: doc/sample_serializer.md
Name: sample_serializer

Overview:
- Downstream stage of the waveform segment selector.
- Takes each 8-bit sample byte on a one-cycle load strobe (the selector's trigger pulse) and transmits it as an asynchronous serial frame on tx_out for the DAC/link driver.
- Frame format: start bit, 8 data bits LSB first, optional even parity bit, 1 or 2 stop bits.
- A one-entry holding buffer absorbs a byte that arrives mid-frame, so frames can run back-to-back.

Parameters:
- CLKS_PER_BIT, 16, sysclk cycles per serial bit; legal range 2..255.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- sysclk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe: data_in is valid.
- data_in  input  8  sample byte.
- parity_en  input  1  when 1, the frame includes an even-parity bit; sampled together with data_in.
- clr_ovr  input  1  clears the sticky overrun flag.
- tx_out  output  1  serial line; idle level is 1.
- busy  output  1  a frame is in progress.
- buf_full  output  1  the holding buffer contains a byte.
- overrun  output  1  sticky flag: a byte was dropped.
- frame_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset values: tx_out=1, busy=0, buf_full=0, overrun=0, frame_done=0. The FSM goes to IDLE and the counters clear.
- Reset asserted mid-frame aborts the frame at once, returns tx_out to 1 and discards the buffer.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: load=1 captures data_in and parity_en into the shift register and moves to START. tx_out falls to 0 on the next edge (latency 1 cycle from load). busy rises on that same edge.
- Bit timing: a divider counts 0..CLKS_PER_BIT-1. Each bit lasts exactly CLKS_PER_BIT cycles.
- START lasts 1 bit (tx_out=0), then DATA.
- DATA sends bits 0..7, LSB first, with a 3-bit index. After bit 7 it goes to PARITY if the captured parity_en=1, otherwise to STOP.
- PARITY lasts 1 bit. tx_out = XOR of the 8 data bits, giving even parity over data plus parity.
- STOP lasts STOP_BITS bits with tx_out=1.
- Frame length: (10 + P + STOP_BITS - 1) * CLKS_PER_BIT cycles, where P is 1 when parity is enabled and 0 otherwise.
- frame_done asserts on the last cycle of the last stop bit.
- At frame end with buf_full=1: the buffer moves to the shift register and the next edge enters START directly, with no idle bit. buf_full clears.
- At frame end with buf_full=0 and load=1: data_in starts the next frame directly.
- At frame end with buf_full=0 and load=0: go to IDLE. busy drops on the next edge.
- load while busy with buf_full=0: the byte and its parity_en go into the buffer and buf_full sets.
- load while busy with buf_full=1, and not on a frame-end cycle: the byte is dropped and overrun sets.
- load on a frame-end cycle with buf_full=1: the buffer drains to the shift register and the new byte refills the buffer. buf_full stays 1 and no overrun.
- overrun stays set until clr_ovr=1. If set and clr_ovr occur in the same cycle, set wins.
- The captured parity_en applies per byte. Changing parity_en mid-frame has no effect on the current frame.

Test Plan:
- Reset mid-frame: assert reset at cycle 20 of a 40-cycle frame -> tx_out=1, busy=0 immediately; no frame_done; a subsequent load gives a clean frame.
- Single frame: CLKS_PER_BIT=4, parity off, load 0xA5 -> tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; frame_done at cycle 40 after load; busy low after.
- Parity frame: load 0x07 with parity_en=1, STOP_BITS=2 -> bits 0,1,1,1,0,0,0,0,0,1 (parity),1,1; frame is 48 cycles.
- Back-to-back: load 0x11, then load 0x22 at cycle 10 -> buf_full=1 until frame end; the 0x22 start bit immediately follows the 0x11 stop bit with no idle gap; two frame_done pulses 40 cycles apart.
- Overrun: loads at cycles 0, 5, 9 -> third byte dropped, overrun=1; clr_ovr pulse -> 0; clr_ovr coincident with another drop -> stays 1.
- Frame-end coincidence: buf_full=1 and load on the frame_done cycle -> no overrun, buf_full remains 1, three frames sent in order.
